// File: rtl/proximity_presence_detector_pkg.sv
// Shared definitions for the ultrasonic presence path: widths, default cm
// limits, presence FSM state encoding and a median-of-three helper.
package ultrasonic_pkg;

    localparam int DIST_W = 10;
    localparam int SUM_W  = 12;
    localparam int RUN_W  = 8;
    localparam int REJ_W  = 8;

    localparam int MAX_CM_DEF  = 400;
    localparam int NEAR_CM_DEF = 30;
    localparam int FAR_CM_DEF  = 40;

    typedef enum logic [1:0] {
        ST_ABSENT    = 2'd0,
        ST_ARMING    = 2'd1,
        ST_PRESENT   = 2'd2,
        ST_RELEASING = 2'd3
    } pres_state_e;

    // Middle value of three distances: max(min(a,b), min(max(a,b),c)).
    function automatic logic [DIST_W-1:0] median3(
        input logic [DIST_W-1:0] a,
        input logic [DIST_W-1:0] b,
        input logic [DIST_W-1:0] c
    );
        logic [DIST_W-1:0] lo;
        logic [DIST_W-1:0] hi;
        logic [DIST_W-1:0] mid;
        lo  = (a < b) ? a : b;
        hi  = (a < b) ? b : a;
        mid = (hi < c) ? hi : c;
        return (lo > mid) ? lo : mid;
    endfunction

endpackage

// File: rtl/proximity_presence_detector_if.sv
// Distance input and presence/average outputs of the presence detector.
// master: the ranging stage / consumer side; slave: the detector.
interface proximity_presence_detector_if;
    import ultrasonic_pkg::*;

    logic [DIST_W-1:0] dist_in;
    logic [DIST_W-1:0] avg_dist;
    logic              avg_valid;
    logic              presence;
    logic              presence_rise;
    logic              presence_fall;
    logic [REJ_W-1:0]  reject_cnt;

    modport master (
        output dist_in,
        input  avg_dist, avg_valid, presence, presence_rise, presence_fall, reject_cnt
    );

    modport slave (
        input  dist_in,
        output avg_dist, avg_valid, presence, presence_rise, presence_fall, reject_cnt
    );
endinterface

// File: rtl/proximity_presence_detector_dist_window_avg.sv
// Four-entry moving-average window. A shifted-in sample updates the window,
// fill count and running sum; the average is registered one cycle later and
// only once the window is full. upd_o pulses with every average update.
module dist_window_avg
    import ultrasonic_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_i,
    input  logic [DIST_W-1:0] sample_i,
    output logic [DIST_W-1:0] avg_o,
    output logic              valid_o,
    output logic              upd_o
);
    logic [3:0][DIST_W-1:0] win_q;
    logic [2:0]             fill_q;
    logic [SUM_W-1:0]       sum_q;
    logic                   pend_q;
    logic [DIST_W-1:0]      avg_q;
    logic                   valid_q;
    logic                   upd_q;

    // Shift window, keep running sum (oldest out, newest in), saturate fill at 4.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_q  <= '0;
            fill_q <= 3'd0;
            sum_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            pend_q <= shift_i;
            if (shift_i) begin
                win_q <= {win_q[2:0], sample_i};
                sum_q <= sum_q - SUM_W'(win_q[3]) + SUM_W'(sample_i);
                if (fill_q != 3'd4) begin
                    fill_q <= fill_q + 3'd1;
                end
            end
        end
    end

    // Register the truncated average one cycle after a shift into a full window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avg_q   <= '0;
            valid_q <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            upd_q <= 1'b0;
            if (pend_q && (fill_q == 3'd4)) begin
                avg_q   <= DIST_W'(sum_q >> 2);
                valid_q <= 1'b1;
                upd_q   <= 1'b1;
            end
        end
    end

    assign avg_o   = avg_q;
    assign valid_o = valid_q;
    assign upd_o   = upd_q;
endmodule

// File: rtl/proximity_presence_detector.sv
// Proximity presence detector: periodic sampling of the ranging distance,
// reject counting, optional median-of-3 pre-filter (define MEDIAN3_EN),
// moving average and a hysteresis FSM producing presence and edge pulses.
module proximity_presence_detector
    import ultrasonic_pkg::*;
#(
    parameter int SAMPLE_CYCLES = 50_000_000,
    parameter int MAX_CM        = MAX_CM_DEF,
    parameter int NEAR_CM       = NEAR_CM_DEF,
    parameter int FAR_CM        = FAR_CM_DEF,
    parameter int ARM_COUNT     = 3,
    parameter int HOLD_COUNT    = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    proximity_presence_detector_if.slave bus
);
    localparam int CNT_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

    logic [CNT_W-1:0]  cnt_q;
    logic              tick_s;
    logic              accept_s;
    logic [REJ_W-1:0]  rej_q;
    logic              win_shift_s;
    logic [DIST_W-1:0] win_sample_s;
    logic [DIST_W-1:0] avg_s;
    logic              avg_valid_s;
    logic              avg_upd_s;
    logic              near_s;
    logic              far_s;
    logic [RUN_W-1:0]  run_inc_s;
    pres_state_e       state_q;
    logic [RUN_W-1:0]  run_q;
    logic              pres_q;
    logic              rise_q;
    logic              fall_q;

    assign tick_s    = (cnt_q == CNT_W'(SAMPLE_CYCLES - 1));
    assign accept_s  = tick_s && (bus.dist_in != '0) && (bus.dist_in <= DIST_W'(MAX_CM));
    assign near_s    = (avg_s <= DIST_W'(NEAR_CM));
    assign far_s     = (avg_s >= DIST_W'(FAR_CM));
    assign run_inc_s = run_q + RUN_W'(1);

    // Sample period counter; the terminal value is the sampling tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (tick_s) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Count out-of-range samples, saturating at the counter maximum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rej_q <= '0;
        end else if (tick_s && !accept_s && (rej_q != '1)) begin
            rej_q <= rej_q + REJ_W'(1);
        end
    end

`ifdef MEDIAN3_EN
    logic [DIST_W-1:0] h1_q;
    logic [DIST_W-1:0] h2_q;
    logic [DIST_W-1:0] med_q;
    logic [1:0]        hcnt_q;
    logic              med_vld_q;

    // Median of the last three accepted samples; the first two pass raw.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h1_q      <= '0;
            h2_q      <= '0;
            med_q     <= '0;
            hcnt_q    <= 2'd0;
            med_vld_q <= 1'b0;
        end else begin
            med_vld_q <= accept_s;
            if (accept_s) begin
                if (hcnt_q < 2'd2) begin
                    med_q  <= bus.dist_in;
                    hcnt_q <= hcnt_q + 2'd1;
                end else begin
                    med_q <= median3(bus.dist_in, h1_q, h2_q);
                end
                h2_q <= h1_q;
                h1_q <= bus.dist_in;
            end
        end
    end

    assign win_shift_s  = med_vld_q;
    assign win_sample_s = med_q;
`else
    assign win_shift_s  = accept_s;
    assign win_sample_s = bus.dist_in;
`endif

    dist_window_avg u_win (
        .clk      (clk),
        .reset    (reset),
        .shift_i  (win_shift_s),
        .sample_i (win_sample_s),
        .avg_o    (avg_s),
        .valid_o  (avg_valid_s),
        .upd_o    (avg_upd_s)
    );

    // Hysteresis FSM, stepped once per average update, with registered edge pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ABSENT;
            run_q   <= '0;
            pres_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (avg_upd_s) begin
                case (state_q)
                    ST_ABSENT: begin
                        if (near_s) begin
                            if (ARM_COUNT == 1) begin
                                state_q <= ST_PRESENT;
                                run_q   <= '0;
                                pres_q  <= 1'b1;
                                rise_q  <= 1'b1;
                            end else begin
                                state_q <= ST_ARMING;
                                run_q   <= RUN_W'(1);
                            end
                        end
                    end
                    ST_ARMING: begin
                        if (!near_s) begin
                            state_q <= ST_ABSENT;
                            run_q   <= '0;
                        end else if (run_inc_s >= RUN_W'(ARM_COUNT)) begin
                            state_q <= ST_PRESENT;
                            run_q   <= '0;
                            pres_q  <= 1'b1;
                            rise_q  <= 1'b1;
                        end else begin
                            run_q <= run_inc_s;
                        end
                    end
                    ST_PRESENT: begin
                        if (far_s) begin
                            if (HOLD_COUNT == 1) begin
                                state_q <= ST_ABSENT;
                                run_q   <= '0;
                                pres_q  <= 1'b0;
                                fall_q  <= 1'b1;
                            end else begin
                                state_q <= ST_RELEASING;
                                run_q   <= RUN_W'(1);
                            end
                        end
                    end
                    ST_RELEASING: begin
                        if (!far_s) begin
                            state_q <= ST_PRESENT;
                            run_q   <= '0;
                        end else if (run_inc_s >= RUN_W'(HOLD_COUNT)) begin
                            state_q <= ST_ABSENT;
                            run_q   <= '0;
                            pres_q  <= 1'b0;
                            fall_q  <= 1'b1;
                        end else begin
                            run_q <= run_inc_s;
                        end
                    end
                    default: begin
                        state_q <= ST_ABSENT;
                        run_q   <= '0;
                        pres_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.avg_dist      = avg_s;
    assign bus.avg_valid     = avg_valid_s;
    assign bus.presence      = pres_q;
    assign bus.presence_rise = rise_q;
    assign bus.presence_fall = fall_q;
    assign bus.reject_cnt    = rej_q;
endmodule

// File: tb/tb_proximity_presence_detector.sv
// Self-checking bench for proximity_presence_detector (SAMPLE_CYCLES=10).
// Reference model: sample history queues, arithmetic average and streak counts.
module tb_proximity_presence_detector;

    localparam int N    = 10;
    localparam int ARM  = 3;
    localparam int HOLD = 6;
`ifdef MEDIAN3_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    proximity_presence_detector_if pif ();

    proximity_presence_detector #(
        .SAMPLE_CYCLES (N),
        .ARM_COUNT     (ARM),
        .HOLD_COUNT    (HOLD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (pif)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int rise_seen = 0;
    int fall_seen = 0;

    // Count observed presence pulses.
    always @(negedge clk) begin
        if (pif.presence_rise === 1'b1) rise_seen <= rise_seen + 1;
        if (pif.presence_fall === 1'b1) fall_seen <= fall_seen + 1;
    end

    // Reference model state
    int acc[$];
    int win[$];
    int m_avg = 0;
    bit m_valid = 0;
    bit m_pres = 0;
    int streak = 0;
    int m_rej = 0;
    int m_rise = 0;
    int m_fall = 0;
    int offset = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int mid3(input int a, input int b, input int c);
        int s[3];
        int t;
        s[0] = a; s[1] = b; s[2] = c;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2 - i; j++)
                if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
        return s[1];
    endfunction

    task automatic model_sample(input int d);
        int v;
        bit near, far;
        if (d == 0 || d > 400) begin
            if (m_rej < 255) m_rej++;
            return;
        end
        v = d;
`ifdef MEDIAN3_EN
        acc.push_back(d);
        if (acc.size() > 3) void'(acc.pop_front());
        if (acc.size() == 3) v = mid3(acc[0], acc[1], acc[2]);
`endif
        win.push_back(v);
        if (win.size() > 4) void'(win.pop_front());
        if (win.size() < 4) return;
        m_avg = (win[0] + win[1] + win[2] + win[3]) / 4;
        m_valid = 1;
        near = (m_avg <= 30);
        far  = (m_avg >= 40);
        if (!m_pres) begin
            streak = near ? streak + 1 : 0;
            if (streak >= ARM) begin m_pres = 1; streak = 0; m_rise++; end
        end else begin
            streak = far ? streak + 1 : 0;
            if (streak >= HOLD) begin m_pres = 0; streak = 0; m_fall++; end
        end
    endtask

    task automatic check_all(input string where);
        chk({where, ".avg_dist"},   32'(pif.avg_dist),      m_valid ? 32'(m_avg) : 32'd0);
        chk({where, ".avg_valid"},  32'(pif.avg_valid),     32'(m_valid));
        chk({where, ".presence"},   32'(pif.presence),      32'(m_pres));
        chk({where, ".reject_cnt"}, 32'(pif.reject_cnt),    32'(m_rej));
        chk({where, ".rise_count"}, 32'(rise_seen),         32'(m_rise));
        chk({where, ".fall_count"}, 32'(fall_seen),         32'(m_fall));
    endtask

    task automatic do_tick(input int d, input string where);
        pif.dist_in = 10'(d);
        repeat (N - offset) @(negedge clk);
        model_sample(d);
        repeat (LAT) @(negedge clk);
        offset = LAT;
        check_all(where);
    endtask

    task automatic run_const(input int d, input int n, input string where);
        for (int i = 0; i < n; i++) do_tick(d, where);
    endtask

    task automatic model_clear();
        acc.delete(); win.delete();
        m_avg = 0; m_valid = 0; m_pres = 0; streak = 0; m_rej = 0;
        offset = 0;
    endtask

    task automatic check_zero(input string where);
        chk({where, ".avg_dist"},   32'(pif.avg_dist),      32'd0);
        chk({where, ".avg_valid"},  32'(pif.avg_valid),     32'd0);
        chk({where, ".presence"},   32'(pif.presence),      32'd0);
        chk({where, ".rise"},       32'(pif.presence_rise), 32'd0);
        chk({where, ".fall"},       32'(pif.presence_fall), 32'd0);
        chk({where, ".reject_cnt"}, 32'(pif.reject_cnt),    32'd0);
    endtask

    // Asynchronous reset applied between edges; outputs must clear at once.
    task automatic do_reset(input string where);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_zero(where);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        int d;
        int r;
        reset = 1'b1;
        pif.dist_in = 10'd0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        model_clear();

        // Window fill with 100 cm, then approach to arm presence.
        run_const(100, 4, "fill100");
        run_const(100, 3, "far100");
        run_const(20, 7, "near20");

        // Alternating out-of-range samples saturate the reject counter.
        for (int i = 0; i < 300; i++) do_tick((i % 2 == 0) ? 0 : 500, "reject");

        // Hovering in the releasing region then coming back near.
        run_const(50, 5, "rel50");
        run_const(20, 1, "back20");
        run_const(50, 10, "leave50");

        // Hysteresis band while absent and while present.
        run_const(35, 6, "hold35_abs");
        run_const(20, 8, "arm20");
        run_const(35, 8, "hold35_pres");

        // Exact threshold values: 30 is near, 40 is far.
        do_reset("rst_a");
        run_const(30, 7, "edge30");
        run_const(40, 10, "edge40");
        run_const(400, 1, "max400");
        run_const(401, 1, "rej401");

        // Reset in the middle of arming.
        do_reset("rst_b");
        run_const(20, 5, "arming");
        do_reset("rst_arming");
        run_const(20, 8, "rearm");

        // Single spike among steady near readings.
        run_const(20, 4, "pre_spike");
        run_const(300, 1, "spike");
        run_const(20, 4, "post_spike");

        // Randomized distances around the thresholds plus out-of-range values.
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 19);
            if (r == 0)      d = 0;
            else if (r == 1) d = $urandom_range(401, 1023);
            else if (r == 2) d = 400;
            else if (r < 10) d = $urandom_range(10, 45);
            else             d = $urandom_range(20, 60);
            do_tick(d, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
